uart_rx_pkt_parser: RTL and testbench
=====================================

Name: uart_rx_pkt_parser

Overview:
- Downstream consumer of the UART receiver. Takes its one-cycle byte strobes (valid/data/break) and assembles framed packets of the form SOF, LEN, LEN payload bytes, CHK.
- Validates each packet and buffers the payload internally.
- Replays the payload on a valid/ready byte stream with a last marker.
- Reports malformed, timed-out, aborted or overrun packets on a one-cycle error strobe.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame byte value.
- MAX_LEN, 16, maximum payload length in bytes; LEN field values 1..MAX_LEN are legal.
- TIMEOUT_CYCLES, 55000, maximum clk cycles allowed between consecutive bytes inside a packet (11 bit times at 5000 cycles/bit).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  one-cycle strobe: a received byte is present (driven by uart_rx_valid).
- in_data  in  8  received byte, sampled only when in_valid=1.
- in_break  in  1  BREAK indication; only meaningful when in_valid=1.
- out_valid  out  1  payload byte available.
- out_ready  in  1  sink accepts the byte; a transfer occurs when out_valid and out_ready are both 1.
- out_data  out  8  payload byte.
- out_last  out  1  marks the final payload byte of the packet.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  3  error cause, valid while err_valid=1: 1=CHK, 2=LEN, 3=TMO, 4=BRK, 5=OVR.

Behaviour:
- Reset: the already-decided reset is resetn, synchronous, active-low; clock is clk. On reset:
  - state=IDLE;
  - out_valid, out_last, err_valid = 0;
  - err_code = 0;
  - out_data = 0;
  - all counters and the checksum accumulator = 0.
- Reset mid-packet or mid-SEND discards everything; out_valid is 0 in the first cycle after reset.
- Storage: payload buffer of MAX_LEN x 8 registers.
- Widths:
  - length and pointer registers are $clog2(MAX_LEN+1) bits;
  - the timeout counter is wide enough for TIMEOUT_CYCLES;
  - the checksum is an 8-bit sum that wraps modulo 256.
- FSM states: IDLE, LEN, DATA, CHK, SEND. Transitions occur only on in_valid unless noted otherwise.
- IDLE:
  - in_valid, in_break=0 and in_data==SOF_BYTE -> LEN;
  - all other bytes are silently discarded;
  - a break in IDLE raises no error.
- LEN:
  - in_data in 1..MAX_LEN: latch len, set checksum=in_data, clear the write pointer, go to DATA;
  - otherwise: raise err LEN and go to IDLE.
- DATA:
  - store in_data at the write pointer, add it to the checksum, increment the write pointer;
  - after the len-th byte, go to CHK.
- CHK:
  - in_data==checksum: go to SEND, with the read pointer cleared;
  - otherwise: raise err CHK and go to IDLE.
- SEND:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1);
  - on a transfer, rd_ptr increments;
  - a transfer while out_last=1 returns the FSM to IDLE, and out_valid=0 in the following cycle.
- Latency: a CHK byte strobe in cycle N gives out_valid=1 in cycle N+1.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable. No timeout applies in SEND.
- Break: in_valid with in_break=1 in LEN, DATA or CHK raises err BRK and returns to IDLE. Break takes precedence over any data interpretation.
- Overrun: any in_valid in SEND raises err OVR and drops the byte. The packet currently being sent continues unaffected. A SOF arriving during SEND is not captured.
- Timeout:
  - in LEN, DATA and CHK the timeout counter increments each cycle and clears on in_valid;
  - reaching TIMEOUT_CYCLES raises err TMO and returns to IDLE;
  - the counter is cleared in IDLE and SEND.
- Error strobe:
  - err_valid is registered: high for exactly one cycle after the cycle of the offending event;
  - err_code holds its value until the next error.
  - Only one error can occur per cycle; priority is BRK > TMO > LEN/CHK/OVR.
- Back-to-back packets: the SOF of the next packet is accepted in the first IDLE cycle after the last transfer.

Test Plan:
- Good packet A5 03 11 22 33 69 -> out 11, 22, 33 with out_ready=1; out_last only on 33; out_valid rises 1 cycle after the 69 strobe; no err_valid.
- Bad checksum A5 03 11 22 33 68 -> err_valid one cycle with err_code=1; out_valid never asserted; a following good packet is parsed correctly.
- Length violation: A5 00 -> err_code=2; A5 11 (17) -> err_code=2; both return to IDLE.
- Timeout and break:
  - A5 02 AA, then silence for 55000 cycles -> err_code=3, exactly once.
  - A5 02, then a break strobe (data 00) -> err_code=4.
- Back-pressure: good packet with out_ready low for 10 cycles per byte -> data stable while stalled; an extra byte strobe mid-SEND -> err_code=5 and the payload is still delivered intact.
- Reset: assert resetn=0 during SEND after 1 of 3 bytes -> out_valid=0 the next cycle; a subsequent good packet decodes normally.

Source files
------------

// File: rtl/uart_rx_pkt_parser.sv
// uart_rx_pkt_parser
//   Assembles packets framed as SOF, LEN, LEN payload bytes, CHK out of the
//   UART receiver's one-cycle byte strobes. A packet is accepted only if its
//   length is legal and CHK matches the 8-bit sum of LEN and the payload. An
//   accepted payload is buffered, then replayed on a valid/ready byte stream
//   that marks the final byte with out_last. Malformed, timed-out, aborted
//   (break) or overrun packets are reported on a one-cycle error strobe.
//
// Ports
//   clk        system clock
//   resetn     synchronous active-low reset
//   in_valid   one-cycle strobe, a received byte is present
//   in_data    received byte (sampled with in_valid)
//   in_break   BREAK indication (qualified by in_valid)
//   out_valid  payload byte available
//   out_ready  sink accepts the byte
//   out_data   payload byte
//   out_last   final payload byte of the packet
//   err_valid  one-cycle error strobe
//   err_code   1=CHK 2=LEN 3=TMO 4=BRK 5=OVR, held until the next error
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | hunting for SOF; everything else (including breaks) ignored
// ST_LEN   | waiting for the length byte
// ST_DATA  | storing payload bytes into the buffer
// ST_CHK   | waiting for the checksum byte
// ST_SEND  | replaying the buffered payload on out_*; input bytes are overruns

module uart_rx_pkt_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 55000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_break,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err_valid,
  output logic [2:0] err_code
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] ERR_CHK = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_TMO = 3'd3;
  localparam logic [2:0] ERR_BRK = 3'd4;
  localparam logic [2:0] ERR_OVR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_SEND
  } state_t;

  state_t        state;
  logic [7:0]    buf_mem [MAX_LEN];
  logic [PW-1:0] len;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    chk_sum;

  logic in_packet;
  logic byte_ok;
  logic brk_hit;
  logic tmo_hit;

  assign in_packet = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign byte_ok   = in_valid && !in_break;
  assign brk_hit   = in_valid && in_break;
  // in_valid clears the counter, so a timeout never coincides with a byte.
  assign tmo_hit   = !in_valid && (tmo_cnt == TMO_LAST);
  assign rd_nxt    = rd_ptr + PTR_ONE;

  // Payload storage is write-only from DATA and needs no reset: it is always
  // fully rewritten before SEND can read it.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && byte_ok) begin
      buf_mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      len       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tmo_cnt   <= '0;
      chk_sum   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      err_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (byte_ok && in_data == SOF_BYTE) begin
            state <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (byte_ok) begin
            if (in_data != 8'd0 && in_data <= MAX_LEN_B) begin
              len     <= PW'(in_data);
              chk_sum <= in_data;
              wr_ptr  <= '0;
              state   <= ST_DATA;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (byte_ok) begin
            chk_sum <= chk_sum + in_data;
            wr_ptr  <= wr_ptr + PTR_ONE;
            if (wr_ptr == len - PTR_ONE) begin
              state <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (byte_ok) begin
            if (in_data == chk_sum) begin
              rd_ptr    <= '0;
              out_valid <= 1'b1;
              out_data  <= buf_mem[0];
              out_last  <= (len == PTR_ONE);
              state     <= ST_SEND;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHK;
              state     <= ST_IDLE;
            end
          end
        end

        ST_SEND: begin
          // Bytes arriving while we replay are dropped; the replay carries on.
          if (in_valid) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OVR;
          end
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              rd_ptr   <= rd_nxt;
              out_data <= buf_mem[rd_nxt[AW-1:0]];
              out_last <= (rd_nxt == len - PTR_ONE);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Break and timeout override whatever the per-state logic decided.
      if (in_packet) begin
        tmo_cnt <= in_valid ? '0 : tmo_cnt + TMO_ONE;
        if (brk_hit) begin
          err_valid <= 1'b1;
          err_code  <= ERR_BRK;
          state     <= ST_IDLE;
        end else if (tmo_hit) begin
          err_valid <= 1'b1;
          err_code  <= ERR_TMO;
          tmo_cnt   <= '0;
          state     <= ST_IDLE;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
module tb_uart_rx_pkt_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 55000;
  localparam logic [7:0] SOF     = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       err_valid;
  logic [2:0] err_code;

  uart_rx_pkt_parser #(
    .SOF_BYTE      (SOF),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_break (in_break),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .err_valid(err_valid),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nxfer  = 0;
  int rdy_mode = 1;          // 0 random, 1 always ready, 2 never, 3 long stalls
  logic [8:0] exp_q[$];      // {last, data}
  logic [2:0] exp_err[$];
  logic [7:0] pl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic b);
    in_valid = 1'b1;
    in_data  = d;
    in_break = b;
    tick();
    in_valid = 1'b0;
    in_break = 1'b0;
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) tick();
  endtask

  // Reference: the checksum is LEN plus all payload bytes, modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] lb, input logic [7:0] p[$]);
    logic [7:0] s;
    s = lb;
    foreach (p[i]) s = s + p[i];
    return s;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 20000; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      tick();
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Sends one packet and queues what the spec says must come out of it.
  task automatic issue_packet(input logic [7:0] lb, input logic [7:0] p[$], input logic [7:0] chk,
                              input int gmax, input bit lat_chk, input bit ovr, input bit drain);
    bit good;
    drive_byte(SOF, 1'b0);
    gap(gmax);
    if (lb == 8'd0 || int'(lb) > MAX_LEN) begin
      exp_err.push_back(3'd2);
      drive_byte(lb, 1'b0);
      gap(gmax);
      return;
    end
    good = (chk == sum8(lb, p));
    if (good) begin
      foreach (p[i]) exp_q.push_back({(i == p.size() - 1), p[i]});
    end else begin
      exp_err.push_back(3'd1);
    end
    drive_byte(lb, 1'b0);
    gap(gmax);
    foreach (p[i]) begin
      drive_byte(p[i], 1'b0);
      gap(gmax);
    end
    drive_byte(chk, 1'b0);
    if (lat_chk) check("latency_out_valid", 32'(out_valid), 32'd1);
    if (good && ovr) begin
      repeat (2) tick();
      exp_err.push_back(3'd5);
      drive_byte(SOF, 1'b0);
    end
    if (good && drain) wait_drain();
    gap(gmax);
  endtask

  task automatic rand_payload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // out_ready driver
  initial begin
    int c;
    c = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ((c % 11) == 10);
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [8:0] e;
    logic       pv_stall;
    logic [7:0] pd;
    logic       pl_last;
    logic       perr;
    logic [2:0] pcode;
    logic       prst;
    pv_stall = 1'b0; pd = '0; pl_last = 1'b0; perr = 1'b0; pcode = '0; prst = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && prst) begin
        if (pv_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(pd));
          check("stall_last", 32'(out_last), 32'(pl_last));
        end
        if (perr && !err_valid) check("err_code_hold", 32'(err_code), 32'(pcode));
      end
      if (resetn && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %02h with nothing expected at %0t", out_data, $time);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_last", 32'(out_last), 32'(e[8]));
          nxfer++;
        end
      end
      if (resetn && err_valid) begin
        if (exp_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got code %0d with nothing expected at %0t", err_code, $time);
        end else begin
          check("err_code", 32'(err_code), 32'(exp_err.pop_front()));
        end
      end
      pv_stall = out_valid && !out_ready;
      pd       = out_data;
      pl_last  = out_last;
      perr     = err_valid;
      pcode    = err_code;
      prst     = resetn;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    logic [7:0] lb;
    logic [7:0] jd;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_break = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    resetn = 1'b1;
    tick();

    // Good packet with latency check
    rdy_mode = 1;
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    issue_packet(8'h03, pl, 8'h69, 0, 1'b1, 1'b0, 1'b1);

    // Bad checksum, then a good packet
    issue_packet(8'h03, pl, 8'h68, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    issue_packet(8'h03, pl, 8'h69, 1, 1'b0, 1'b0, 1'b1);

    // Length violations
    pl.delete();
    issue_packet(8'h00, pl, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    issue_packet(8'h11, pl, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    rand_payload(MAX_LEN);
    issue_packet(8'(MAX_LEN), pl, sum8(8'(MAX_LEN), pl), 0, 1'b0, 1'b0, 1'b1);

    // Break inside a packet
    exp_err.push_back(3'd4);
    drive_byte(SOF, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h00, 1'b1);
    repeat (3) tick();
    // Break while idle is silent
    drive_byte(8'h00, 1'b1);
    repeat (3) tick();

    // Timeout
    exp_err.push_back(3'd3);
    drive_byte(SOF, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'hAA, 1'b0);
    k = 0;
    while (k <= TMO + 20) begin
      k++;
      tick();
      if (err_valid) break;
    end
    checks++;
    if (k < TMO - 2 || k > TMO + 2) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d expected about %0d", k, TMO);
    end
    repeat (300) tick();

    // Back-pressure with an overrun byte (a SOF) in the middle of SEND
    rdy_mode = 3;
    rand_payload(4);
    issue_packet(8'd4, pl, sum8(8'd4, pl), 0, 1'b0, 1'b1, 1'b1);
    rdy_mode = 1;
    rand_payload(2);
    issue_packet(8'd2, pl, sum8(8'd2, pl), 0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    rdy_mode = 0;
    for (int n = 0; n < 60; n++) begin
      int t;
      int ln;
      repeat ($urandom_range(0, 2)) begin
        jd = 8'($urandom_range(0, 255));
        if (jd == SOF) jd = 8'h5A;
        drive_byte(jd, 1'($urandom_range(0, 1)));
      end
      t  = $urandom_range(0, 9);
      ln = $urandom_range(1, MAX_LEN);
      rand_payload(ln);
      if (t <= 5) begin
        issue_packet(8'(ln), pl, sum8(8'(ln), pl), 2, 1'b0, 1'b0, 1'b1);
      end else if (t == 6) begin
        issue_packet(8'(ln), pl, sum8(8'(ln), pl) + 8'($urandom_range(1, 255)), 2, 1'b0, 1'b0, 1'b1);
      end else if (t == 7) begin
        lb = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        issue_packet(lb, pl, 8'h00, 2, 1'b0, 1'b0, 1'b1);
      end else begin
        int cut;
        cut = $urandom_range(1, ln + 2);   // break replaces frame byte index cut
        exp_err.push_back(3'd4);
        drive_byte(SOF, 1'b0);
        if (cut > 1) drive_byte(8'(ln), 1'b0);
        for (int i = 0; i < cut - 2 && i < ln; i++) drive_byte(pl[i], 1'b0);
        drive_byte(8'($urandom_range(0, 255)), 1'b1);
        gap(2);
      end
    end

    // Reset in the middle of SEND
    rdy_mode = 1;
    repeat (5) tick();
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    n0 = nxfer;
    issue_packet(8'h03, pl, 8'h69, 0, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (nxfer == n0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_wait_first_xfer", 32'(nxfer > n0), 32'd1);
    resetn = 1'b0;
    exp_q.delete();
    tick();
    check("midsend_rst_out_valid", 32'(out_valid), 32'd0);
    check("midsend_rst_out_last", 32'(out_last), 32'd0);
    check("midsend_rst_out_data", 32'(out_data), 32'd0);
    resetn = 1'b1;
    tick();
    issue_packet(8'h03, pl, 8'h69, 0, 1'b1, 1'b0, 1'b1);

    repeat (20) tick();
    check("exp_out_empty", 32'(exp_q.size()), 32'd0);
    check("exp_err_empty", 32'(exp_err.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
